// File: rtl/pool1_fmap_buffer_pkg.sv
// pool1_fmap_buffer_pkg
// Shared constants for the layer-1 pooled feature-map buffer: default map
// geometry, channel count, int8 quantisation limits, read-FSM state codes,
// the sideband carried with every output beat, and the saturation helper.
package pool1_fmap_buffer_pkg;

  localparam int FMAP_W_DEF     = 12;
  localparam int FMAP_H_DEF     = 12;
  localparam int DATA_WIDTH_DEF = 8;
  localparam int NUM_CH         = 6;

  localparam int Q_W   = 8;
  localparam int Q_MIN = -128;
  localparam int Q_MAX = 127;

  localparam logic [0:0] S_IDLE   = 1'b0;
  localparam logic [0:0] S_STREAM = 1'b1;

  typedef struct packed {
    logic [2:0] ch;
    logic [3:0] row;
    logic [3:0] col;
    logic       last;
  } beat_meta_t;

  function automatic logic signed [Q_W-1:0] sat_q(input logic signed [31:0] v);
    if (v > Q_MAX) return Q_W'(Q_MAX);
    else if (v < Q_MIN) return Q_W'(Q_MIN);
    return v[Q_W-1:0];
  endfunction

endpackage

// File: rtl/fmap_ram.sv
// fmap_ram
// Simple dual-port RAM, one write port and one read port with a registered
// (1-cycle) read. No reset: contents are don't-care after power-up.
//   clk      : clock
//   i_we     : write enable        i_waddr/i_wdata : write address / data
//   i_re     : read enable         i_raddr         : read address
//   o_rdata  : read data, valid the cycle after i_re
module fmap_ram #(
  parameter int WIDTH = 48,
  parameter int AW    = 9
) (
  input  logic             clk,
  input  logic             i_we,
  input  logic [AW-1:0]    i_waddr,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_re,
  input  logic [AW-1:0]    i_raddr,
  output logic [WIDTH-1:0] o_rdata
);

  logic [WIDTH-1:0] r_mem [2**AW];

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
    if (i_re) o_rdata <= r_mem[i_raddr];
  end

endmodule

// File: rtl/pool1_fmap_buffer.sv
// pool1_fmap_buffer
// Ping-pong buffer between the layer-1 pool and conv2. Pooled pixels arrive
// in raster order with all six channels per strobe; each is saturated to
// int8 and stored as one packed word. A full bank is streamed out
// channel-major (ch0 raster, then ch1 .. ch5) on a valid/ready interface.
//   clk, rst              : clock, async active-high reset
//   valid_in, in_ch0..5   : pooled pixel strobe and six 32-bit values
//   out_valid/out_ready   : output handshake
//   out_data, out_ch, out_row, out_col, out_last : beat payload
//   overflow              : sticky, set when an input beat is dropped
//
// Read FSM
//   state    | meaning
//   S_IDLE   | waiting for bank_full[rd_bank]
//   S_STREAM | issuing reads of rd_bank until the out_last beat is accepted
module pool1_fmap_buffer
  import pool1_fmap_buffer_pkg::*;
#(
  parameter int FMAP_W     = FMAP_W_DEF,
  parameter int FMAP_H     = FMAP_H_DEF,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         valid_in,
  input  logic [31:0]                  in_ch0,
  input  logic [31:0]                  in_ch1,
  input  logic [31:0]                  in_ch2,
  input  logic [31:0]                  in_ch3,
  input  logic [31:0]                  in_ch4,
  input  logic [31:0]                  in_ch5,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic signed [DATA_WIDTH-1:0] out_data,
  output logic [2:0]                   out_ch,
  output logic [3:0]                   out_row,
  output logic [3:0]                   out_col,
  output logic                         out_last,
  output logic                         overflow
);

  localparam int DEPTH  = FMAP_W * FMAP_H;
  localparam int AW     = $clog2(DEPTH);
  localparam int WORD_W = NUM_CH * DATA_WIDTH;

  logic [31:0]                  w_in [NUM_CH];
  logic [WORD_W-1:0]            w_wr_word;
  logic [WORD_W-1:0]            w_rd_word;
  logic signed [DATA_WIDTH-1:0] w_rd_lane [NUM_CH];

  logic [1:0]    r_bank_full;
  logic          r_wr_bank, r_rd_bank;
  logic [AW-1:0] r_wr_addr;
  logic          r_overflow;

  logic [0:0]    r_state;
  logic [2:0]    r_rd_ch;
  logic [3:0]    r_rd_row, r_rd_col;
  logic [AW-1:0] r_rd_addr;
  logic          r_issue_done;
  logic          r_pend;
  beat_meta_t    r_pend_meta;

  logic [1:0]                   r_cnt;
  logic signed [DATA_WIDTH-1:0] r_d0, r_d1;
  beat_meta_t                   r_m0, r_m1;

  logic w_wr_en, w_wr_wrap, w_pop, w_release, w_issue;
  logic w_col_end, w_row_end, w_ch_end;
  logic [1:0] w_set_mask, w_clr_mask;

  assign w_in[0] = in_ch0;
  assign w_in[1] = in_ch1;
  assign w_in[2] = in_ch2;
  assign w_in[3] = in_ch3;
  assign w_in[4] = in_ch4;
  assign w_in[5] = in_ch5;

  always_comb begin
    w_wr_word = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      w_wr_word[i*DATA_WIDTH +: DATA_WIDTH] = DATA_WIDTH'(sat_q(w_in[i]));
      w_rd_lane[i] = w_rd_word[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // ---------------- write side ----------------
  assign w_wr_en    = valid_in && !r_bank_full[r_wr_bank];
  assign w_wr_wrap  = w_wr_en && (r_wr_addr == AW'(DEPTH - 1));
  // Set and clear always target different banks (one is empty, one is full),
  // so both take effect in the same cycle.
  assign w_set_mask = {2{w_wr_wrap}} & {r_wr_bank, ~r_wr_bank};
  assign w_clr_mask = {2{w_release}} & {r_rd_bank, ~r_rd_bank};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_bank_full <= 2'b00;
      r_wr_bank   <= 1'b0;
      r_wr_addr   <= '0;
      r_overflow  <= 1'b0;
    end else begin
      r_bank_full <= (r_bank_full & ~w_clr_mask) | w_set_mask;
      if (valid_in && r_bank_full[r_wr_bank]) r_overflow <= 1'b1;
      if (w_wr_en) begin
        if (w_wr_wrap) begin
          r_wr_addr <= '0;
          r_wr_bank <= ~r_wr_bank;
        end else begin
          r_wr_addr <= r_wr_addr + AW'(1);
        end
      end
    end
  end

  fmap_ram #(.WIDTH(WORD_W), .AW(AW + 1)) u_ram (
    .clk     (clk),
    .i_we    (w_wr_en),
    .i_waddr ({r_wr_bank, r_wr_addr}),
    .i_wdata (w_wr_word),
    .i_re    (w_issue),
    .i_raddr ({r_rd_bank, r_rd_addr}),
    .o_rdata (w_rd_word)
  );

  // ---------------- read side ----------------
  assign w_pop     = (r_cnt != 2'd0) && out_ready;
  assign w_release = w_pop && r_m0.last;
  assign w_col_end = (r_rd_col == 4'(FMAP_W - 1));
  assign w_row_end = (r_rd_row == 4'(FMAP_H - 1));
  assign w_ch_end  = (r_rd_ch == 3'(NUM_CH - 1));
  // Issue only if the skid will still have room when the RAM data lands,
  // counting the read already in flight.
  assign w_issue   = (r_state == S_STREAM) && !r_issue_done &&
                     (({1'b0, r_cnt} + {2'b00, r_pend}) <= (3'd1 + {2'b00, w_pop}));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_rd_bank    <= 1'b0;
      r_rd_ch      <= '0;
      r_rd_row     <= '0;
      r_rd_col     <= '0;
      r_rd_addr    <= '0;
      r_issue_done <= 1'b0;
      r_pend       <= 1'b0;
      r_pend_meta  <= '0;
    end else begin
      r_pend <= w_issue;
      case (r_state)
        S_IDLE:   if (r_bank_full[r_rd_bank]) r_state <= S_STREAM;
        default: begin
          if (w_release) begin
            r_state      <= S_IDLE;
            r_rd_bank    <= ~r_rd_bank;
            r_issue_done <= 1'b0;
          end
        end
      endcase
      if (w_issue) begin
        r_pend_meta <= '{ch: r_rd_ch, row: r_rd_row, col: r_rd_col,
                         last: w_ch_end && w_row_end && w_col_end};
        if (w_col_end) begin
          r_rd_col <= '0;
          if (w_row_end) begin
            r_rd_row  <= '0;
            r_rd_addr <= '0;
            if (w_ch_end) begin
              r_rd_ch      <= '0;
              r_issue_done <= 1'b1;
            end else begin
              r_rd_ch <= r_rd_ch + 3'd1;
            end
          end else begin
            r_rd_row  <= r_rd_row + 4'd1;
            r_rd_addr <= r_rd_addr + AW'(1);
          end
        end else begin
          r_rd_col  <= r_rd_col + 4'd1;
          r_rd_addr <= r_rd_addr + AW'(1);
        end
      end
    end
  end

  // 2-entry skid: entry 0 is the presented beat, entry 1 absorbs the read
  // that was in flight when the consumer stalled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= 2'd0;
      r_d0  <= '0;
      r_d1  <= '0;
      r_m0  <= '0;
      r_m1  <= '0;
    end else begin
      case ({r_pend, w_pop})
        2'b01: begin
          r_d0  <= r_d1;
          r_m0  <= r_m1;
          r_cnt <= r_cnt - 2'd1;
        end
        2'b10: begin
          if (r_cnt == 2'd0) begin
            r_d0 <= w_rd_lane[r_pend_meta.ch];
            r_m0 <= r_pend_meta;
          end else begin
            r_d1 <= w_rd_lane[r_pend_meta.ch];
            r_m1 <= r_pend_meta;
          end
          r_cnt <= r_cnt + 2'd1;
        end
        2'b11: begin
          if (r_cnt == 2'd1) begin
            r_d0 <= w_rd_lane[r_pend_meta.ch];
            r_m0 <= r_pend_meta;
          end else begin
            r_d0 <= r_d1;
            r_m0 <= r_m1;
            r_d1 <= w_rd_lane[r_pend_meta.ch];
            r_m1 <= r_pend_meta;
          end
        end
        default: ;
      endcase
    end
  end

  assign out_valid = (r_cnt != 2'd0);
  assign out_data  = r_d0;
  assign out_ch    = r_m0.ch;
  assign out_row   = r_m0.row;
  assign out_col   = r_m0.col;
  assign out_last  = r_m0.last;
  assign overflow  = r_overflow;

endmodule

// File: tb/tb_pool1_fmap_buffer.sv
module tb_pool1_fmap_buffer;

  localparam int W    = 12;
  localparam int H    = 12;
  localparam int NPIX = W * H;
  localparam int NCH  = 6;

  logic              clk = 1'b0;
  logic              rst;
  logic              valid_in;
  logic [31:0]       tb_in [NCH];
  logic              out_valid, out_ready;
  logic signed [7:0] out_data;
  logic [2:0]        out_ch;
  logic [3:0]        out_row, out_col;
  logic              out_last, overflow;

  pool1_fmap_buffer dut (
    .clk(clk), .rst(rst), .valid_in(valid_in),
    .in_ch0(tb_in[0]), .in_ch1(tb_in[1]), .in_ch2(tb_in[2]),
    .in_ch3(tb_in[3]), .in_ch4(tb_in[4]), .in_ch5(tb_in[5]),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_ch(out_ch), .out_row(out_row), .out_col(out_col),
    .out_last(out_last), .overflow(overflow)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic [19:0] exp_q [$];   // {data, ch, row, col, last}, in stream order
  int          held    = 0; // frames accepted and not yet fully streamed
  logic        exp_ovf = 1'b0;
  int          beat_idx = 0;
  int          cyc = 0;
  int          first_cyc = 0;
  logic        rate_chk = 1'b0;
  int          ready_mode = 0; // 0 always ready, 1 random 50%, 2 never

  function automatic int clamp(input int v);
    if (v > 127) return 127;
    if (v < -128) return -128;
    return v;
  endfunction

  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = ($urandom_range(1) == 1);
      default: out_ready = 1'b0;
    endcase
  end

  // Monitor: scoreboard, hold-stability while stalled, sustained rate.
  logic [19:0] prev_beat;
  logic        have_prev = 1'b0;
  always @(negedge clk) begin
    logic [19:0] cur, e;
    cyc++;
    cur = {out_data, out_ch, out_row, out_col, out_last};
    if (rst) begin
      have_prev = 1'b0;
    end else begin
      if (have_prev) begin
        check("stall_valid", 64'(out_valid), 64'd1);
        check("stall_hold", 64'(cur), 64'(prev_beat));
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("extra_beat", 64'(cur), 64'hFFFFF);
        end else begin
          e = exp_q.pop_front();
          check($sformatf("beat%0d", beat_idx), 64'(cur), 64'(e));
          if (beat_idx == 0) first_cyc = cyc;
          beat_idx++;
          if (e[0]) begin
            if (rate_chk) check("rate_no_bubbles", 64'(cyc - first_cyc), 64'd863);
            held--;
            beat_idx = 0;
          end
        end
      end
      have_prev = out_valid && !out_ready;
      prev_beat = cur;
    end
  end

  // ---------------- stimulus ----------------
  task automatic write_frame(input int kind, input int gap_pct);
    int   raw [NPIX][NCH];
    logic accept;
    for (int p = 0; p < NPIX; p++) begin
      for (int c = 0; c < NCH; c++) begin
        if (kind == 0) raw[p][c] = (c == 0) ? (p % 128) : -(p % 128);
        else if ($urandom_range(3) == 0) raw[p][c] = int'($urandom);
        else raw[p][c] = int'($urandom_range(400)) - 200;
      end
    end
    if (kind != 0) begin
      raw[0][3] = 400;
      raw[0][4] = -512;
    end
    accept = (held < 2);
    if (accept) begin
      held++;
      for (int c = 0; c < NCH; c++)
        for (int p = 0; p < NPIX; p++)
          exp_q.push_back({8'(clamp(raw[p][c])), 3'(c), 4'(p / W), 4'(p % W),
                           (c == NCH - 1) && (p == NPIX - 1)});
    end else begin
      exp_ovf = 1'b1;
    end
    @(posedge clk); #1;
    for (int p = 0; p < NPIX; p++) begin
      while (gap_pct > 0 && int'($urandom_range(99)) < gap_pct) begin
        valid_in = 1'b0;
        for (int c = 0; c < NCH; c++) tb_in[c] = $urandom;
        @(posedge clk); #1;
      end
      valid_in = 1'b1;
      for (int c = 0; c < NCH; c++) tb_in[c] = 32'(raw[p][c]);
      @(posedge clk); #1;
    end
    valid_in = 1'b0;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_valid"}, 64'(out_valid), 64'd0);
    check({tag, "_data"},  64'(out_data),  64'd0);
    check({tag, "_ch"},    64'(out_ch),    64'd0);
    check({tag, "_row"},   64'(out_row),   64'd0);
    check({tag, "_col"},   64'(out_col),   64'd0);
    check({tag, "_last"},  64'(out_last),  64'd0);
    check({tag, "_ovf"},   64'(overflow),  64'd0);
  endtask

  task automatic clear_model();
    exp_q.delete();
    held     = 0;
    exp_ovf  = 1'b0;
    beat_idx = 0;
  endtask

  task automatic pulse_reset(input string tag);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check_zero(tag);
    clear_model();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic drain(input string tag);
    int b = 0;
    while (exp_q.size() != 0 && b < 20000) begin
      @(negedge clk);
      b++;
    end
    check({tag, "_drained"}, 64'(exp_q.size() == 0), 64'd1);
    repeat (8) @(negedge clk);
    check({tag, "_idle"}, 64'(out_valid), 64'd0);
    check({tag, "_ovf"}, 64'(overflow), 64'(exp_ovf));
  endtask

  initial begin
    #800000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int k, b;
    rst = 1'b1;
    valid_in = 1'b0;
    out_ready = 1'b0;
    for (int c = 0; c < NCH; c++) tb_in[c] = '0;
    repeat (3) @(posedge clk);
    #1;
    check_zero("in_reset");
    rst = 1'b0;
    @(posedge clk); #1;
    check_zero("after_reset");

    // Ramp frame, always ready: order, data, last, first-valid latency, rate.
    ready_mode = 0;
    rate_chk = 1'b1;
    write_frame(0, 0);
    k = 1;
    while (k < 8) begin
      @(posedge clk); #1;
      if (out_valid) break;
      k++;
    end
    check("first_valid_within_3", 64'(k <= 3), 64'd1);
    drain("ramp");

    // Random frame with out-of-range values (saturation), always ready.
    write_frame(1, 0);
    drain("sat");
    rate_chk = 1'b0;

    // Random backpressure and input gaps.
    ready_mode = 1;
    write_frame(1, 30);
    drain("bp");

    // Three frames while stalled: third dropped, overflow sticky.
    ready_mode = 2;
    repeat (2) @(posedge clk);
    write_frame(0, 0);
    write_frame(1, 0);
    write_frame(1, 0);
    repeat (4) @(posedge clk);
    #1;
    check("stalled_ovf", 64'(overflow), 64'(exp_ovf));
    check("stalled_valid", 64'(out_valid), 64'd1);
    ready_mode = 1;
    drain("drop");

    // Write the second frame while the first streams.
    pulse_reset("rst2");
    ready_mode = 0;
    write_frame(0, 0);
    write_frame(1, 20);
    drain("overlap");

    // Reset in the middle of a stream, then a clean frame.
    write_frame(1, 0);
    b = 0;
    while (beat_idx < 400 && b < 5000) begin
      @(negedge clk);
      b++;
    end
    check("reached_beat400", 64'(beat_idx >= 400), 64'd1);
    #1;
    rst = 1'b1;
    #1;
    check_zero("midrst");
    clear_model();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    write_frame(0, 0);
    drain("after_midrst");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/pool1_fmap_buffer.md
POOL1_FMAP_BUFFER -- requirements
Module: pool1_fmap_buffer

Interface
REQ-001 SHALL have parameter FMAP_W, default 12, pooled feature-map width.
REQ-002 SHALL have parameter FMAP_H, default 12, pooled feature-map height.
REQ-003 SHALL have parameter DATA_WIDTH, default 8, stored element width in bits, signed.
REQ-004 SHALL have port clk, input, 1 bit, the single clock; all logic is on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit, asynchronous active-high reset.
REQ-006 SHALL have port valid_in, input, 1 bit, pooled pixel strobe from the layer-1 pool.
REQ-007 SHALL have ports in_ch0..in_ch5, input, 32 bits each, sign-extended int8 pooled values arriving in raster order.
REQ-008 SHALL have port out_valid, output, 1 bit, stream beat valid.
REQ-009 SHALL have port out_ready, input, 1 bit, downstream (conv2) accepts the beat.
REQ-010 SHALL have port out_data, output, DATA_WIDTH bits, signed element.
REQ-011 SHALL have port out_ch, output, 3 bits, channel index of the beat.
REQ-012 SHALL have ports out_row and out_col, output, 4 bits each, position of the beat.
REQ-013 SHALL have port out_last, output, 1 bit, final beat of a frame.
REQ-014 SHALL have port overflow, output, 1 bit, sticky flag for dropped input.

Function
REQ-015 SHALL saturate each in_chN to [-128,127] before storing it.
REQ-016 SHALL hold two banks (ping-pong), each FMAP_W*FMAP_H words of 6*DATA_WIDTH bits, with the 6 channels packed per address.
REQ-017 SHALL write each valid_in beat to wr_bank at wr_addr, then advance wr_addr raster-wise (0..143).
REQ-018 SHALL set bank_full[wr_bank], clear wr_addr and toggle wr_bank on the write at wr_addr==143.
REQ-019 SHALL drop a valid_in beat when bank_full[wr_bank] is set, set overflow, and leave wr_addr unchanged.
REQ-020 SHALL implement read FSM IDLE->STREAM when bank_full[rd_bank] is set, and STREAM->IDLE after the out_last beat is accepted.
REQ-021 On leaving STREAM, SHALL clear bank_full[rd_bank] and toggle rd_bank.
REQ-022 SHALL read channel-major: ch0 all rows/cols raster, then ch1 .. ch5; 864 beats per frame.
REQ-023 SHALL assert out_last only on the beat ch=5, row=11, col=11.
REQ-024 A beat SHALL transfer when out_valid && out_ready; out_data/out_ch/out_row/out_col/out_last SHALL stay stable while out_valid && !out_ready.
REQ-025 With out_ready held high, SHALL sustain 1 beat/cycle with no bubbles inside a frame.
REQ-026 First out_valid SHALL occur at most 3 cycles after the bank_full set caused by the final write.
REQ-027 When a write completes a bank and a read releases the other bank in the same cycle, both updates SHALL take effect; no beat is lost.
REQ-028 SHALL be able to write one bank while streaming the other.

Reset
REQ-029 During and after reset: out_valid=0, out_data=0, out_ch=0, out_row=0, out_col=0, out_last=0, overflow=0.
REQ-030 Reset SHALL clear bank_full, wr_bank, rd_bank, wr_addr and read counters, and force the FSM to IDLE.
REQ-031 Reset mid-frame SHALL abandon partial writes and streams; RAM contents need not be cleared.

Structure
REQ-032 FMAP_W/FMAP_H defaults, channel count 6, and FSM state encodings SHALL live in a shared header alongside the quantisation parameters.
REQ-033 Storage SHALL be one sub-module, fmap_ram: a simple dual-port RAM with 1-cycle registered read, instantiated once with the bank bit as the address MSB.
REQ-034 The output path SHALL use a 2-entry skid to hide RAM read latency under backpressure.

Verification
REQ-035 Frame with ch0=value (r*12+c) mod 128 and other channels negated, out_ready=1 -> 864 beats in order, data matching, out_last on beat 863.
REQ-036 in_ch3=32'h0000_0190 (400) and in_ch4=32'hFFFF_FE00 (-512) -> stored as 127 and -128.
REQ-037 out_ready toggling with a 50% random pattern -> no duplicated or missing beats; outputs held stable while stalled.
REQ-038 Three back-to-back frames with out_ready=0 -> first two frames stored, third frame dropped, overflow=1; out_ready released -> frames 1 and 2 stream intact.
REQ-039 Frame 2 written while frame 1 streams -> both frames streamed in order, overflow=0.
REQ-040 rst pulsed at beat 400 of the stream -> outputs go to zero immediately; the next full frame streams correctly from ch0 (0,0).
